fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch PC generator and I-cache request tracker: the stage directly upstream of the BTB/predictor block.
//  Holds the fetch PC and drives it to the I-cache and to the BTB lookup.
//  Chooses the next PC from redirect, BTB target or PC+4.
//  Tracks outstanding I-cache requests and tags returned instructions with PC and prediction.
//  Drops returns that belong to the wrong path after a redirect.
// PARAMETERS
//  ADDR       32          address width
//  RESET_VEC  'h0         PC loaded by reset
//  MAX_OUT    4           max outstanding I-cache requests (power of 2, >=2); also tag FIFO depth
//  OUT        derived     $clog2(MAX_OUT+1), width of the outstanding and kill counters
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous reset, active-high
//  stall_       in   1     low = downstream fetch queue full, do not issue
//  redirect_    in   1     low = writeback mispredict/jump miss, restart fetch
//  redirect_pc  in   ADDR  correct target for the redirect
//  fetch_pc     out  ADDR  current PC; feeds the BTB lookup and the I-cache address
//  btb_hit      in   1     BTB hit for fetch_pc (combinational from lookup)
//  btb_addr     in   ADDR  predicted target for fetch_pc
//  ic_req_      out  1     low = I-cache fetch request at fetch_pc
//  ic_ack_      in   1     low = request accepted this cycle (same-cycle handshake)
//  ic_ret_      in   1     low = one instruction returned; returns arrive in request order
//  inst_e_      out  1     low = valid instruction to the fetch stage
//  inst_pc      out  ADDR  PC of the returned instruction
//  inst_pred    out  1     predicted-taken flag of that instruction
//  inst_pred_pc out  ADDR  predicted next PC of that instruction
// BEHAVIOUR
//  - State reset values: pc=RESET_VEC, state=RUN, out_cnt=0, kill_cnt=0, FIFO empty.
//  - Output reset values: ic_req_=1, inst_e_=1, inst_pc=0, inst_pred=0, inst_pred_pc=0.
//  - reset overrides all other inputs in the same cycle; outstanding requests in flight at reset are forgotten.
//  - States: RUN, HOLD, REDIR.
//    RUN->HOLD when stall_=0. HOLD->RUN when stall_=1.
//    any state->REDIR when redirect_=0. REDIR->RUN after exactly 1 bubble cycle.
//  - ic_req_ = 0 only if all hold: state RUN, stall_=1, redirect_=1, out_cnt<MAX_OUT. It is combinational from these inputs.
//  - Accept (ic_req_=0 and ic_ack_=0):
//    FIFO push {pc, pred, npc}. out_cnt+1.
//    pc <= npc, where npc = btb_hit ? btb_addr : pc+4. pred = btb_hit.
//  - Request not acked: pc holds and the request repeats next cycle (request-hold protocol).
//  - Return (ic_ret_=0): FIFO pop. out_cnt-1.
//    If kill_cnt=0: inst_e_=0 that cycle with the popped tag (combinational from FIFO head).
//    Else: inst_e_=1 (return dropped), kill_cnt-1.
//  - Redirect (redirect_=0): pc <= redirect_pc. state <= REDIR.
//    kill_cnt <= out_cnt - (ic_ret_==0).
//    A return in the same cycle is dropped: inst_e_=1.
//    A redirect during REDIR restarts REDIR with the newest redirect_pc.
//  - Accept and return in the same cycle: out_cnt unchanged, FIFO pushes and pops. A full FIFO cannot push, because ic_req_ is masked at out_cnt=MAX_OUT.
//  - ic_ret_ with out_cnt=0 is a protocol error; an assertion fires in simulation.
//  - PC arithmetic is modulo 2^ADDR; pc+4 wraps from 'hFFFFFFFC to 0.
//  - fetch_pc is registered pc. BTB lookup latency is 0, so the target is used in the request cycle.
// CONFIGURATION
//  - FETCH_BTB_PRED_EN defined: npc and pred are as above.
//  - FETCH_BTB_PRED_EN undefined: btb_hit/btb_addr are ignored; npc=pc+4, pred=0, inst_pred=0 always.
// TESTING
//  - Reset, RESET_VEC='h100, stall_=1, ic_ack_=0 each cycle, no BTB hit:
//    fetch_pc=100,104,108,10C on consecutive cycles.
//    Requests stop at out_cnt=4 until ic_ret_.
//  - BTB: btb_hit=1, btb_addr='h200 when fetch_pc='h104:
//    next fetch_pc='h200; the return for 104 gives inst_pred=1, inst_pred_pc='h200.
//    With the macro undefined, the next PC is 'h108 and inst_pred=0.
//  - Redirect with out_cnt=3 and ic_ret_=0 in the same cycle, redirect_pc='h400:
//    that return is dropped; the next 2 returns are dropped (inst_e_=1).
//    ic_req_=1 for 1 bubble cycle, then a request at 'h400; its return gives inst_e_=0, inst_pc='h400.
//  - stall_=0 for 3 cycles mid-stream: ic_req_=1 and fetch_pc frozen; returns still deliver.
//    After stall_=1, fetch resumes at the held PC with no gap or duplicate.
//  - ic_ack_=1 for 2 cycles: fetch_pc holds and ic_req_ stays 0; on ack, exactly one FIFO entry is pushed.
//  - Wrap: fetch_pc='hFFFFFFFC accepted -> next fetch_pc=0.
//    Reset asserted with out_cnt=2: all counters are 0 next cycle and later ic_ret_ triggers the error assertion.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator and I-cache request tracker; tags returns with PC/prediction and drops wrong-path returns.
// Build option: define FETCH_BTB_PRED_EN to steer fetch with BTB predictions (default: sequential fetch).
module fetch_pc_gen #(
  parameter int ADDR = 32,
  parameter logic [ADDR-1:0] RESET_VEC = '0,
  parameter int MAX_OUT = 4,
  localparam int OUT = $clog2(MAX_OUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_,
  input  logic            redirect_,
  input  logic [ADDR-1:0] redirect_pc,
  output logic [ADDR-1:0] fetch_pc,
  input  logic            btb_hit,
  input  logic [ADDR-1:0] btb_addr,
  output logic            ic_req_,
  input  logic            ic_ack_,
  input  logic            ic_ret_,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic            inst_pred,
  output logic [ADDR-1:0] inst_pred_pc
);

  localparam int PTR = $clog2(MAX_OUT);

  typedef enum logic [1:0] {RUN, HOLD, REDIR} state_t;

  state_t          state_reg, state_next;
  logic [ADDR-1:0] pc_reg, pc_next, npc;
  logic            pred;
  logic [OUT-1:0]  out_cnt_reg, out_cnt_next;
  logic [OUT-1:0]  kill_cnt_reg, kill_cnt_next;
  logic [PTR-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic            req, accept, pop, deliver;

  logic [ADDR-1:0] tag_pc_reg   [MAX_OUT];
  logic [ADDR-1:0] tag_npc_reg  [MAX_OUT];
  logic            tag_pred_reg [MAX_OUT];

`ifdef FETCH_BTB_PRED_EN
  assign pred = btb_hit;
  assign npc  = btb_hit ? btb_addr : pc_reg + ADDR'(4);
`else
  logic unused_btb;
  assign unused_btb = ^{btb_hit, btb_addr};
  assign pred = 1'b0;
  assign npc  = pc_reg + ADDR'(4);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // Next-state logic; a redirect wins from any state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (!stall_) state_next = HOLD;
      HOLD:    if (stall_)  state_next = RUN;
      default: state_next = RUN;
    endcase
    if (!redirect_) state_next = REDIR;
  end

  // Output logic: request only while running, unstalled, not redirecting and below the credit limit
  always_comb begin
    req = 1'b0;
    if (!reset && state_reg == RUN && stall_ && redirect_ && out_cnt_reg < OUT'(MAX_OUT))
      req = 1'b1;
  end

  assign ic_req_  = ~req;
  assign accept   = req & ~ic_ack_;
  assign pop      = ~reset & ~ic_ret_ & (out_cnt_reg != '0);
  assign deliver  = pop & redirect_ & (kill_cnt_reg == '0);
  assign fetch_pc = pc_reg;

  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (accept && !pop)      out_cnt_next = out_cnt_reg + OUT'(1);
    else if (pop && !accept) out_cnt_next = out_cnt_reg - OUT'(1);

    // Everything in flight at a redirect is wrong-path, except a return consumed this very cycle
    kill_cnt_next = kill_cnt_reg;
    if (!redirect_)                         kill_cnt_next = out_cnt_reg - OUT'(pop);
    else if (pop && kill_cnt_reg != '0)     kill_cnt_next = kill_cnt_reg - OUT'(1);

    pc_next = pc_reg;
    if (!redirect_)   pc_next = redirect_pc;
    else if (accept)  pc_next = npc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_VEC;
      out_cnt_reg  <= '0;
      kill_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      pc_reg       <= pc_next;
      out_cnt_reg  <= out_cnt_next;
      kill_cnt_reg <= kill_cnt_next;
      if (accept) wr_ptr_reg <= wr_ptr_reg + PTR'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + PTR'(1);
    end
  end

  // Tag storage; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_pc_reg[wr_ptr_reg]   <= pc_reg;
      tag_npc_reg[wr_ptr_reg]  <= npc;
      tag_pred_reg[wr_ptr_reg] <= pred;
    end
  end

  assign inst_e_      = ~deliver;
  assign inst_pc      = deliver ? tag_pc_reg[rd_ptr_reg]  : '0;
  assign inst_pred    = deliver ? tag_pred_reg[rd_ptr_reg] : 1'b0;
  assign inst_pred_pc = deliver ? tag_npc_reg[rd_ptr_reg] : '0;

  ret_without_outstanding: assert property (@(posedge clk) disable iff (reset)
    !(!ic_ret_ && out_cnt_reg == '0));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: scenario tasks plus a per-cycle scoreboard monitor.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_ = 1'b1;
  logic        redirect_ = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_pc;
  logic        btb_hit = 1'b0;
  logic [31:0] btb_addr = '0;
  logic        ic_req_;
  logic        ic_ack_ = 1'b1;
  logic        ic_ret_ = 1'b1;
  logic        inst_e_;
  logic [31:0] inst_pc;
  logic        inst_pred;
  logic [31:0] inst_pred_pc;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_BTB_PRED_EN
  localparam logic [31:0] BTB_NEXT = 32'h200;
  localparam logic        EXP_PRED = 1'b1;
`else
  localparam logic [31:0] BTB_NEXT = 32'h118;
  localparam logic        EXP_PRED = 1'b0;
`endif

  fetch_pc_gen #(.ADDR(32), .RESET_VEC(32'h100), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset), .stall_(stall_), .redirect_(redirect_),
    .redirect_pc(redirect_pc), .fetch_pc(fetch_pc), .btb_hit(btb_hit),
    .btb_addr(btb_addr), .ic_req_(ic_req_), .ic_ack_(ic_ack_), .ic_ret_(ic_ret_),
    .inst_e_(inst_e_), .inst_pc(inst_pc), .inst_pred(inst_pred), .inst_pred_pc(inst_pred_pc)
  );

  always #5 clk = ~clk;

  // Scoreboard: tags pushed on each accept, popped on each return
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] ppc;
  } tag_t;

  tag_t        sb[$];
  logic [31:0] m_pc = 32'h100;
  int          m_state = 0;
  int          m_out = 0;
  int          m_kill = 0;

  always @(negedge clk) begin
    logic exp_req, ret, deliver, acc;
    tag_t h, t;
    h = '0;
    exp_req = !reset && m_state == 0 && stall_ && redirect_ && m_out < 4;
    checks++;
    if (ic_req_ !== !exp_req) begin
      errors++;
      $display("FAIL mon_ic_req t=%0t got=%b exp=%b", $time, ic_req_, !exp_req);
    end
    checks++;
    if (fetch_pc !== m_pc) begin
      errors++;
      $display("FAIL mon_fetch_pc t=%0t got=%h exp=%h", $time, fetch_pc, m_pc);
    end
    ret = !reset && !ic_ret_;
    deliver = 1'b0;
    if (ret) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_sb_underflow t=%0t", $time);
        ret = 1'b0;
      end else begin
        h = sb.pop_front();
        deliver = (m_kill == 0) && redirect_;
      end
    end
    checks++;
    if (inst_e_ !== !deliver) begin
      errors++;
      $display("FAIL mon_inst_e t=%0t got=%b exp=%b", $time, inst_e_, !deliver);
    end
    if (deliver) begin
      checks++;
      if ({inst_pc, inst_pred, inst_pred_pc} !== h) begin
        errors++;
        $display("FAIL mon_tag t=%0t got=%h/%b/%h exp=%h/%b/%h", $time,
                 inst_pc, inst_pred, inst_pred_pc, h.pc, h.pred, h.ppc);
      end
    end
    if (reset) begin
      sb.delete();
      m_pc = 32'h100; m_state = 0; m_out = 0; m_kill = 0;
    end else begin
      acc = exp_req && !ic_ack_;
      if (acc) begin
        t.pc = m_pc;
`ifdef FETCH_BTB_PRED_EN
        t.pred = btb_hit;
        t.ppc = btb_hit ? btb_addr : m_pc + 32'd4;
`else
        t.pred = 1'b0;
        t.ppc = m_pc + 32'd4;
`endif
        sb.push_back(t);
        m_pc = t.ppc;
      end
      if (!redirect_) begin
        m_kill = m_out - (ret ? 1 : 0);
        m_pc = redirect_pc;
      end else if (ret && m_kill > 0) begin
        m_kill--;
      end
      m_out = m_out + (acc ? 1 : 0) - (ret ? 1 : 0);
      if (!redirect_) m_state = 2;
      else case (m_state)
        0: if (!stall_) m_state = 1;
        1: if (stall_) m_state = 0;
        default: m_state = 0;
      endcase
    end
    $display("cyc t=%0t req_=%b ack_=%b ret_=%b pc=%h inst_e_=%b inst_pc=%h",
             $time, ic_req_, ic_ack_, ic_ret_, fetch_pc, inst_e_, inst_pc);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1 || inst_e_ !== 1'b1 || inst_pc !== 32'h0 || inst_pred !== 1'b0 || inst_pred_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got req_=%b e_=%b pc=%h pred=%b ppc=%h exp 1/1/0/0/0",
               ic_req_, inst_e_, inst_pc, inst_pred, inst_pred_pc);
    end
    checks++;
    if (fetch_pc !== 32'h100) begin
      errors++;
      $display("FAIL reset_pc got=%h exp=100", fetch_pc);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_req got=%b exp=0", ic_req_);
    end
    cyc();
  endtask

  task automatic test_sequential();
    ic_ack_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = 32'h100 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (fetch_pc !== e || ic_req_ !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc got=%h req_=%b exp=%h req_=0", fetch_pc, ic_req_, e);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1 || fetch_pc !== 32'h110) begin
      errors++;
      $display("FAIL seq_credit_limit got req_=%b pc=%h exp req_=1 pc=110", ic_req_, fetch_pc);
    end
    cyc();
    ic_ack_ = 1'b1;
    ic_ret_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = 32'h100 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (inst_e_ !== 1'b0 || inst_pc !== e) begin
        errors++;
        $display("FAIL seq_return got e_=%b pc=%h exp e_=0 pc=%h", inst_e_, inst_pc, e);
      end
      cyc();
    end
    ic_ret_ = 1'b1;
  endtask

  task automatic test_btb();
    ic_ack_ = 1'b0;
    @(negedge clk);
    cyc();
    btb_hit = 1'b1;
    btb_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h114) begin
      errors++;
      $display("FAIL btb_lookup_pc got=%h exp=114", fetch_pc);
    end
    cyc();
    btb_hit = 1'b0;
    ic_ack_ = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_pc !== BTB_NEXT) begin
      errors++;
      $display("FAIL btb_next_pc got=%h exp=%h", fetch_pc, BTB_NEXT);
    end
    cyc();
    ic_ret_ = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_pc !== 32'h110 || inst_pred !== 1'b0 || inst_pred_pc !== 32'h114) begin
      errors++;
      $display("FAIL btb_ret0 got=%h/%b/%h exp=110/0/114", inst_pc, inst_pred, inst_pred_pc);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (inst_pc !== 32'h114 || inst_pred !== EXP_PRED || inst_pred_pc !== BTB_NEXT) begin
      errors++;
      $display("FAIL btb_ret1 got=%h/%b/%h exp=114/%b/%h", inst_pc, inst_pred, inst_pred_pc, EXP_PRED, BTB_NEXT);
    end
    cyc();
    ic_ret_ = 1'b1;
  endtask

  task automatic test_redirect();
    ic_ack_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = BTB_NEXT + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (fetch_pc !== e) begin
        errors++;
        $display("FAIL redir_fill got=%h exp=%h", fetch_pc, e);
      end
      cyc();
    end
    ic_ack_ = 1'b1;
    redirect_ = 1'b0;
    redirect_pc = 32'h400;
    ic_ret_ = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_e_ !== 1'b1 || ic_req_ !== 1'b1) begin
      errors++;
      $display("FAIL redir_same_cycle got e_=%b req_=%b exp 1/1", inst_e_, ic_req_);
    end
    cyc();
    redirect_ = 1'b1;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1 || inst_e_ !== 1'b1 || fetch_pc !== 32'h400) begin
      errors++;
      $display("FAIL redir_bubble got req_=%b e_=%b pc=%h exp 1/1/400", ic_req_, inst_e_, fetch_pc);
    end
    cyc();
    ic_ack_ = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b0 || inst_e_ !== 1'b1 || fetch_pc !== 32'h400) begin
      errors++;
      $display("FAIL redir_restart got req_=%b e_=%b pc=%h exp 0/1/400", ic_req_, inst_e_, fetch_pc);
    end
    cyc();
    ic_ack_ = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_e_ !== 1'b0 || inst_pc !== 32'h400) begin
      errors++;
      $display("FAIL redir_first_ret got e_=%b pc=%h exp 0/400", inst_e_, inst_pc);
    end
    cyc();
    ic_ret_ = 1'b1;
  endtask

  task automatic test_stall();
    ic_ack_ = 1'b0;
    cyc();
    cyc();
    stall_ = 1'b0;
    ic_ret_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ic_req_ !== 1'b1 || fetch_pc !== 32'h40C) begin
        errors++;
        $display("FAIL stall_frozen got req_=%b pc=%h exp 1/40c", ic_req_, fetch_pc);
      end
      if (i < 2) begin
        checks++;
        if (inst_e_ !== 1'b0 || inst_pc !== 32'h404 + 32'(4 * i)) begin
          errors++;
          $display("FAIL stall_deliver got e_=%b pc=%h exp 0/%h", inst_e_, inst_pc, 32'h404 + 32'(4 * i));
        end
      end
      cyc();
      if (i == 1) ic_ret_ = 1'b1;
    end
    stall_ = 1'b1;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold_exit got req_=%b exp 1", ic_req_);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b0 || fetch_pc !== 32'h40C) begin
      errors++;
      $display("FAIL stall_resume got req_=%b pc=%h exp 0/40c", ic_req_, fetch_pc);
    end
    cyc();
    ic_ack_ = 1'b1;
    ic_ret_ = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h410 || inst_pc !== 32'h40C) begin
      errors++;
      $display("FAIL stall_after got pc=%h inst_pc=%h exp 410/40c", fetch_pc, inst_pc);
    end
    cyc();
    ic_ret_ = 1'b1;
  endtask

  task automatic test_ack_hold();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ic_req_ !== 1'b0 || fetch_pc !== 32'h410) begin
        errors++;
        $display("FAIL ackhold_wait got req_=%b pc=%h exp 0/410", ic_req_, fetch_pc);
      end
      cyc();
    end
    ic_ack_ = 1'b0;
    @(negedge clk);
    cyc();
    ic_ack_ = 1'b1;
    ic_ret_ = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h414 || inst_e_ !== 1'b0 || inst_pc !== 32'h410) begin
      errors++;
      $display("FAIL ackhold_single got pc=%h e_=%b inst_pc=%h exp 414/0/410", fetch_pc, inst_e_, inst_pc);
    end
    cyc();
    ic_ret_ = 1'b1;
  endtask

  task automatic test_wrap();
    redirect_ = 1'b0;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_ = 1'b1;
    @(negedge clk);
    cyc();
    ic_ack_ = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b0 || fetch_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req got req_=%b pc=%h exp 0/fffffffc", ic_req_, fetch_pc);
    end
    cyc();
    ic_ack_ = 1'b1;
    ic_ret_ = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_pred_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc got pc=%h inst_pc=%h ppc=%h exp 0/fffffffc/0", fetch_pc, inst_pc, inst_pred_pc);
    end
    cyc();
    ic_ret_ = 1'b1;
  endtask

  task automatic test_reset_midstream();
    ic_ack_ = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    ic_ack_ = 1'b1;
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1 || inst_e_ !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs got req_=%b e_=%b exp 1/1", ic_req_, inst_e_);
    end
    cyc();
    reset = 1'b0;
    ic_ack_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = 32'h100 + 32'(4 * i);
      @(negedge clk);
      checks++;
      if (ic_req_ !== 1'b0 || fetch_pc !== e) begin
        errors++;
        $display("FAIL midreset_refill got req_=%b pc=%h exp 0/%h", ic_req_, fetch_pc, e);
      end
      cyc();
    end
    @(negedge clk);
    checks++;
    if (ic_req_ !== 1'b1) begin
      errors++;
      $display("FAIL midreset_credit got req_=%b exp 1", ic_req_);
    end
    cyc();
    ic_ack_ = 1'b1;
    ic_ret_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (inst_pc !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL midreset_ret got=%h exp=%h", inst_pc, 32'h100 + 32'(4 * i));
      end
      cyc();
    end
    ic_ret_ = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_btb();
    test_redirect();
    test_stall();
    test_ack_hold();
    test_wrap();
    test_reset_midstream();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
